// File: rtl/urd_rx_fdec_ctrl_mc.sv
// Multi-channel rx frame-decoder controller: round-robin channel grant,
// header/payload read sequencing, segment chaining and fd job writes.
// Optional per-frame watchdog enabled by defining URD_RX_FDEC_TIMEOUT_EN.
module urd_rx_fdec_ctrl_mc #(
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int ERR_W      = 8,
    parameter int MAX_CONCAT = 8
`ifdef URD_RX_FDEC_TIMEOUT_EN
   ,parameter int TIMEOUT_CYC = 255
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   job_avail,
    input  logic [NUM_CH-1:0]   job_e,
    input  logic [3*NUM_CH-1:0] job_err_type,
    input  logic [NUM_CH-1:0]   zero_payload,
    input  logic [NUM_CH-1:0]   rxf_lower_dav,
    input  logic [NUM_CH-1:0]   rxf_upper_dav,
    input  logic                pq_slot_avail,
    input  logic                pq_slot_avail_early,
    input  logic                rxl_concat,
    input  logic [ERR_W-1:0]    ev_inc_err,
    input  logic [ERR_W-1:0]    ev_oversize_ip,
    input  logic [ERR_W-1:0]    ev_eth_head_err,
    output logic [CH_W-1:0]     ch_id,
    output logic                update_job_info,
    output logic                trigger_pl64_read,
    output logic                trigger_hdr_read,
    output logic                rxl_load_lower_and_trigger,
    output logic                rxl_load_upper,
    output logic                rxf_stop,
    output logic                trigger_write_fd_job_queue,
    output logic                trigger_write_fd_job_queue_error_job,
    output logic [ERR_W-1:0]    err_id,
    output logic                concat_ovf
);

    localparam int CNT_W = (MAX_CONCAT > 2) ? $clog2(MAX_CONCAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PL64,
        S_ERR_HDR,
        S_RXL_WAIT,
        S_CWAIT,
        S_CONCAT
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [CH_W-1:0]   ch_id_q, ch_id_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              zp_q, zp_d;

    logic              gnt_vld;
    logic [CH_W-1:0]   gnt_idx;
    logic [CH_W-1:0]   arb_c;
    logic [2:0]        gnt_et;
    logic              cur_lo;
    logic              cur_up;

    assign ch_id  = ch_id_q;
    assign cur_lo = rxf_lower_dav[ch_id_q];
    assign cur_up = rxf_upper_dav[ch_id_q];
    assign gnt_et = job_err_type[3*gnt_idx +: 3];
    assign zp_d   = zero_payload[ch_id_d];

    // First requesting channel at or after the rr pointer wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        arb_c   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            arb_c = CH_W'((int'(rr_q) + i) % NUM_CH);
            if (!gnt_vld && job_avail[arb_c]) begin
                gnt_vld = 1'b1;
                gnt_idx = arb_c;
            end
        end
    end

`ifdef URD_RX_FDEC_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_q, to_d;
    logic            to_hit;

    assign to_hit = (to_q == TO_W'(TIMEOUT_CYC - 1)) && !(cur_lo || cur_up) &&
                    (state_q == S_PL64 || state_q == S_CONCAT ||
                     state_q == S_ERR_HDR);
`endif

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        ch_id_d = ch_id_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        err_id  = err_q;

        update_job_info                      = 1'b0;
        trigger_pl64_read                    = 1'b0;
        trigger_hdr_read                     = 1'b0;
        rxl_load_lower_and_trigger           = 1'b0;
        rxl_load_upper                       = 1'b0;
        rxf_stop                             = 1'b0;
        trigger_write_fd_job_queue           = 1'b0;
        trigger_write_fd_job_queue_error_job = 1'b0;
        concat_ovf                           = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (pq_slot_avail && gnt_vld) begin
                    update_job_info   = 1'b1;
                    trigger_pl64_read = 1'b1;
                    ch_id_d           = gnt_idx;
                    rr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
                    if (job_e[gnt_idx]) begin
                        trigger_hdr_read = 1'b1;
                        state_d          = S_ERR_HDR;
                        // pre_urd > size > hdr; no type bit counts as hdr
                        if (gnt_et[0])      err_d = ev_inc_err;
                        else if (gnt_et[1]) err_d = ev_oversize_ip;
                        else                err_d = ev_eth_head_err;
                    end else begin
                        state_d = S_PL64;
                    end
                end
            end
            S_ERR_HDR: begin
                if (cur_lo) begin
                    trigger_write_fd_job_queue_error_job = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_PL64: begin
                if (zp_q) begin
                    rxl_load_lower_and_trigger = 1'b1;
                    rxl_load_upper             = 1'b1;
                    trigger_hdr_read           = 1'b1;
                    state_d                    = S_RXL_WAIT;
                end else begin
                    rxl_load_lower_and_trigger = cur_lo;
                    if (cur_up) begin
                        rxl_load_upper   = 1'b1;
                        trigger_hdr_read = 1'b1;
                        state_d          = S_RXL_WAIT;
                    end
                end
            end
            S_RXL_WAIT: begin
                if (!rxl_concat) begin
                    trigger_write_fd_job_queue = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(MAX_CONCAT - 1)) begin
                    concat_ovf = 1'b1;
                    rxf_stop   = 1'b1;
                    trigger_write_fd_job_queue_error_job = 1'b1;
                    err_d   = ev_oversize_ip;
                    err_id  = ev_oversize_ip;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    trigger_write_fd_job_queue = 1'b1;
                    cnt_d             = cnt_q + CNT_W'(1);
                    trigger_pl64_read = pq_slot_avail_early;
                    state_d = pq_slot_avail_early ? S_CONCAT : S_CWAIT;
                end
            end
            S_CWAIT: begin
                if (pq_slot_avail) begin
                    trigger_pl64_read = 1'b1;
                    state_d           = S_CONCAT;
                end
            end
            S_CONCAT: begin
                rxl_load_lower_and_trigger = cur_lo || zp_q;
                if (cur_up) begin
                    rxl_load_upper = 1'b1;
                    state_d        = S_RXL_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef URD_RX_FDEC_TIMEOUT_EN
        if (to_hit && state_d == state_q) begin
            rxf_stop = 1'b1;
            trigger_write_fd_job_queue_error_job = 1'b1;
            err_d   = ev_inc_err;
            err_id  = ev_inc_err;
            state_d = S_IDLE;
        end
        to_d = (state_d != state_q || cur_lo || cur_up) ? '0 : to_q + TO_W'(1);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            ch_id_q <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
            zp_q    <= 1'b0;
`ifdef URD_RX_FDEC_TIMEOUT_EN
            to_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            ch_id_q <= ch_id_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            zp_q    <= zp_d;
`ifdef URD_RX_FDEC_TIMEOUT_EN
            to_q    <= to_d;
`endif
        end
    end

endmodule

// File: tb/tb_urd_rx_fdec_ctrl_mc.sv
// Bench for urd_rx_fdec_ctrl_mc: directed vector table, reset corner case,
// then random stimulus against a frame-level reference model.
module tb_urd_rx_fdec_ctrl_mc;

    localparam logic [8:0] UPD = 9'h100, PL = 9'h080, HDR = 9'h040;
    localparam logic [8:0] LL = 9'h020, LU = 9'h010, STP = 9'h008;
    localparam logic [8:0] WJ = 9'h004, EJ = 9'h002, OVF = 9'h001;
    localparam logic [7:0] C_INC = 8'hA1, C_OVS = 8'hB2, C_HDR = 8'hC3;
    localparam int MAXC = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  job_avail, job_e, zero_payload, rxf_lower_dav, rxf_upper_dav;
    logic [11:0] job_err_type;
    logic        pq_slot_avail, pq_slot_avail_early, rxl_concat;
    logic [7:0]  ev_inc_err, ev_oversize_ip, ev_eth_head_err;
    logic [1:0]  ch_id;
    logic        update_job_info, trigger_pl64_read, trigger_hdr_read;
    logic        rxl_load_lower_and_trigger, rxl_load_upper, rxf_stop;
    logic        trigger_write_fd_job_queue, trigger_write_fd_job_queue_error_job;
    logic        concat_ovf;
    logic [7:0]  err_id;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    urd_rx_fdec_ctrl_mc dut (
        .clk(clk), .rst_n(rst_n),
        .job_avail(job_avail), .job_e(job_e), .job_err_type(job_err_type),
        .zero_payload(zero_payload),
        .rxf_lower_dav(rxf_lower_dav), .rxf_upper_dav(rxf_upper_dav),
        .pq_slot_avail(pq_slot_avail), .pq_slot_avail_early(pq_slot_avail_early),
        .rxl_concat(rxl_concat),
        .ev_inc_err(ev_inc_err), .ev_oversize_ip(ev_oversize_ip),
        .ev_eth_head_err(ev_eth_head_err),
        .ch_id(ch_id), .update_job_info(update_job_info),
        .trigger_pl64_read(trigger_pl64_read), .trigger_hdr_read(trigger_hdr_read),
        .rxl_load_lower_and_trigger(rxl_load_lower_and_trigger),
        .rxl_load_upper(rxl_load_upper), .rxf_stop(rxf_stop),
        .trigger_write_fd_job_queue(trigger_write_fd_job_queue),
        .trigger_write_fd_job_queue_error_job(trigger_write_fd_job_queue_error_job),
        .err_id(err_id), .concat_ovf(concat_ovf)
    );

    typedef struct {
        logic [3:0]  ja, je, zp, lo, up;
        logic [11:0] et;
        logic        pq, pqe, cc;
        logic [8:0]  ex;
        logic [1:0]  ch;
        logic [7:0]  eid;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [3:0] ja, je, input logic [11:0] et,
                               input logic [3:0] zp, lo, up,
                               input logic pq, pqe, cc,
                               input logic [8:0] ex, input logic [1:0] ch,
                               input logic [7:0] eid);
        vec_t r;
        r.ja = ja; r.je = je; r.et = et; r.zp = zp; r.lo = lo; r.up = up;
        r.pq = pq; r.pqe = pqe; r.cc = cc; r.ex = ex; r.ch = ch; r.eid = eid;
        return r;
    endfunction

    task automatic drive(input vec_t t);
        job_avail = t.ja; job_e = t.je; job_err_type = t.et;
        zero_payload = t.zp; rxf_lower_dav = t.lo; rxf_upper_dav = t.up;
        pq_slot_avail = t.pq; pq_slot_avail_early = t.pqe; rxl_concat = t.cc;
    endtask

    task automatic chk(input string nm, input logic [8:0] ex, input logic [1:0] ech,
                       input bit cmp_eid, input logic [7:0] eid);
        logic [8:0] obs;
        obs = {update_job_info, trigger_pl64_read, trigger_hdr_read,
               rxl_load_lower_and_trigger, rxl_load_upper, rxf_stop,
               trigger_write_fd_job_queue, trigger_write_fd_job_queue_error_job,
               concat_ovf};
        vectors++;
        if (obs !== ex || ch_id !== ech || (cmp_eid && err_id !== eid)) begin
            miscompares++;
            $display("FAIL %s: got pulses=%b ch=%0d err=%h, want pulses=%b ch=%0d err=%h",
                     nm, obs, ch_id, err_id, ex, ech, cmp_eid ? eid : err_id);
        end
    endtask

    task automatic run(input vec_t t, input string nm, input bit cmp_eid);
        @(negedge clk);
        drive(t);
        #2;
        chk(nm, t.ex, t.ch, cmp_eid || (t.ex & EJ) != 0, t.eid);
    endtask

    // Frame-level reference model
    int         m_phase;  // 0 idle, 1 first payload, 2 err hdr, 3 result, 4 slot, 5 more payload
    logic [1:0] m_ch;
    int         m_start, m_segs;
    logic [7:0] m_err;
    logic       m_zp;

    function automatic logic [7:0] code_of(input logic [2:0] t);
        if (t[0]) return C_INC;
        if (t[1]) return C_OVS;
        return C_HDR;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_ch = 0; m_start = 0; m_segs = 0; m_err = 0; m_zp = 0;
    endtask

    task automatic model_step(output logic [8:0] ex, output logic [7:0] ev);
        int nph, best, bd, d;
        logic [1:0] nch;
        logic lo, up;
        logic [2:0] et3;
        ex = 0; nph = m_phase; nch = m_ch;
        lo = rxf_lower_dav[m_ch]; up = rxf_upper_dav[m_ch];
        case (m_phase)
            0: if (pq_slot_avail && job_avail != 0) begin
                best = 0; bd = 99;
                for (int c = 0; c < 4; c++) begin
                    d = (c - m_start + 4) % 4;
                    if (job_avail[c] && d < bd) begin bd = d; best = c; end
                end
                nch = 2'(best);
                m_start = (best + 1) % 4;
                ex = UPD | PL;
                if (job_e[best]) begin
                    et3 = 3'((job_err_type >> (3 * best)) & 12'h7);
                    ex |= HDR; m_err = code_of(et3); nph = 2;
                end else nph = 1;
            end
            1: if (m_zp) begin ex = LL | LU | HDR; nph = 3; end
               else begin
                   if (lo) ex |= LL;
                   if (up) begin ex |= LU | HDR; nph = 3; end
               end
            2: if (lo) begin ex = EJ; nph = 0; end
            3: if (!rxl_concat) begin ex = WJ; m_segs = 0; nph = 0; end
               else if (m_segs + 1 == MAXC) begin
                   ex = OVF | STP | EJ; m_err = C_OVS; m_segs = 0; nph = 0;
               end else begin
                   ex = WJ; m_segs++;
                   if (pq_slot_avail_early) begin ex |= PL; nph = 5; end
                   else nph = 4;
               end
            4: if (pq_slot_avail) begin ex = PL; nph = 5; end
            5: begin
                if (lo || m_zp) ex |= LL;
                if (up) begin ex |= LU; nph = 3; end
            end
            default: nph = 0;
        endcase
        ev = m_err;
        m_zp = zero_payload[nch];
        m_phase = nph;
        m_ch = nch;
    endtask

    initial begin
        logic [8:0] ex;
        logic [7:0] ev;
        logic [1:0] ech;
        vec_t z;
        z = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ev_inc_err = C_INC; ev_oversize_ip = C_OVS; ev_eth_head_err = C_HDR;
        rst_n = 1'b0;
        drive(z);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("reset_state", 0, 0, 1, 8'h00);

        // arbitration, dav filtering, error job
        tbl.push_back(v(4'b0101, 0, 0, 0, 0, 0, 1, 0, 0, UPD | PL, 0, 0));
        tbl.push_back(v(4'b0101, 0, 0, 0, 4'b0001, 4'b0001, 1, 0, 0, HDR | LL | LU, 0, 0));
        tbl.push_back(v(4'b0100, 0, 0, 0, 0, 0, 0, 0, 0, WJ, 0, 0));
        tbl.push_back(v(4'b0101, 0, 0, 0, 0, 0, 1, 0, 0, UPD | PL, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 4'b0100, 4'b0001, 0, 0, 0, LL, 2, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 4'b0100, 0, 0, 0, LU | HDR, 2, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, WJ, 2, 0));
        tbl.push_back(v(4'b0110, 4'b0010, 12'h030, 0, 0, 0, 0, 0, 0, 0, 2, 0));
        tbl.push_back(v(4'b0110, 4'b0010, 12'h030, 0, 0, 0, 1, 0, 0, UPD | PL | HDR, 2, 0));
        tbl.push_back(v(0, 0, 0, 0, 4'b1101, 4'b0010, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 4'b0010, 0, 0, 0, 0, EJ, 1, C_OVS));
        // zero payload
        tbl.push_back(v(4'b0001, 0, 0, 4'b0001, 0, 0, 1, 0, 0, UPD | PL, 1, 0));
        tbl.push_back(v(0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, LL | LU | HDR, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, WJ, 0, 0));
        // ch0 and ch1 compete after ch0 grant: ch1 wins; then CWAIT path
        tbl.push_back(v(4'b0011, 0, 0, 0, 0, 0, 1, 0, 0, UPD | PL, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 4'b0010, 4'b0010, 0, 0, 0, LL | LU | HDR, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 1, WJ, 1, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, PL, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 4'b0010, 0, 0, 0, 0, LL, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 4'b0010, 0, 0, 0, LU, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, WJ, 1, 0));
        // concatenation up to overflow on ch2
        tbl.push_back(v(4'b0100, 0, 0, 0, 0, 0, 1, 0, 0, UPD | PL, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 4'b0100, 4'b0100, 0, 0, 0, LL | LU | HDR, 2, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, WJ | PL, 2, 0));
        for (int k = 2; k <= MAXC; k++) begin
            tbl.push_back(v(0, 0, 0, 0, 4'b0100, 4'b0100, 0, 0, 0, LL | LU, 2, 0));
            if (k < MAXC)
                tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, WJ | PL, 2, 0));
            else
                tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, OVF | STP | EJ, 2, C_OVS));
        end
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));

        foreach (tbl[i]) run(tbl[i], $sformatf("tbl%0d", i), 0);

        // reset in the middle of a frame on ch3
        run(v(4'b1000, 0, 0, 0, 0, 0, 1, 0, 0, UPD | PL, 2, 0), "mid_grant", 0);
        @(negedge clk);
        drive(z);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(v(0, 0, 0, 0, 4'b1111, 4'b1111, 0, 0, 0, 0, 0, 0));
        #2;
        chk("mid_reset", 0, 0, 1, 8'h00);
        run(v(4'b1001, 0, 0, 0, 0, 0, 1, 0, 0, UPD | PL, 0, 0), "post_reset_grant", 0);
        run(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_reset_ch", 0);

        // random traffic vs. reference model
        @(negedge clk);
        drive(z);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (3000) begin
            @(negedge clk);
            job_avail           = 4'($urandom);
            job_e               = 4'($urandom & $urandom);
            job_err_type        = 12'($urandom);
            zero_payload        = 4'($urandom & $urandom & $urandom);
            rxf_lower_dav       = 4'($urandom);
            rxf_upper_dav       = 4'($urandom);
            pq_slot_avail       = ($urandom_range(0, 9) < 7);
            pq_slot_avail_early = 1'($urandom);
            rxl_concat          = ($urandom_range(0, 19) < 17);
            #2;
            ech = m_ch;
            model_step(ex, ev);
            chk("random", ex, ech, (ex & EJ) != 0, ev);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
